legv8_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the LEGv8 datapath. It accepts one 32-bit instruction at a time from the fetch unit and latches it into an instruction register (IR). It drives the register-file address selects (Reg2Loc, ReadSelect1/2, WriteSelect) and sequences ALU, data-memory, register write-back and PC-update controls through a FETCH/DECODE/EXEC/MEM/WB state machine. It sits between instruction fetch, the register file, the ALU and data memory, and replaces per-instruction combinational control in the multi-cycle build.

---
 rtl/legv8_multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle control sequencer: latches one instruction into IR and steps it through
// FETCH/DECODE/EXEC/MEM/WB, driving register-file selects and datapath strobes.
module legv8_multicycle_ctrl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] Instruction,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic        Zero,
    input  logic        mem_ack,
    output logic        Reg2Loc,
    output logic [4:0]  ReadSelect1,
    output logic [4:0]  ReadSelect2,
    output logic [4:0]  WriteSelect,
    output logic        ALUSrc,
    output logic [3:0]  ALUOp,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        illegal,
    output logic [31:0] retire_count
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StError} state_e;
    typedef enum logic [2:0] {ClsRtype, ClsLdur, ClsStur, ClsCbz, ClsB, ClsMovk, ClsIllegal} cls_e;

    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOrr   = 4'b0001;
    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluPassB = 4'b0111;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retire_q;
    cls_e        cls;
    logic        dec_reg2loc;
    logic        dec_alusrc;
    logic [3:0]  dec_aluop;

    always_comb begin
        cls         = ClsIllegal;
        dec_reg2loc = 1'b0;
        dec_alusrc  = 1'b0;
        dec_aluop   = AluAnd;
        casez (ir_q[31:21])
            11'b10001011000: begin cls = ClsRtype; dec_aluop = AluAdd; end
            11'b11001011000: begin cls = ClsRtype; dec_aluop = AluSub; end
            11'b10001010000: begin cls = ClsRtype; dec_aluop = AluAnd; end
            11'b10101010000: begin cls = ClsRtype; dec_aluop = AluOrr; end
            11'b11111000010: begin cls = ClsLdur; dec_alusrc = 1'b1; dec_aluop = AluAdd; end
            11'b11111000000: begin
                cls         = ClsStur;
                dec_reg2loc = 1'b1;
                dec_alusrc  = 1'b1;
                dec_aluop   = AluAdd;
            end
            11'b10110100???: begin cls = ClsCbz; dec_reg2loc = 1'b1; dec_aluop = AluPassB; end
            11'b000101?????: cls = ClsB;
            11'b111100101??: begin
                cls         = ClsMovk;
                dec_reg2loc = 1'b1;
                dec_alusrc  = 1'b1;
                dec_aluop   = AluPassB;
            end
            default: cls = ClsIllegal;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        inst_ready = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        unique case (state_q)
            StFetch: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    ir_d    = Instruction;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = (cls == ClsIllegal) ? StError : StExec;
            StExec: begin
                case (cls)
                    ClsRtype, ClsMovk: state_d = StWb;
                    ClsLdur, ClsStur:  state_d = StMem;
                    ClsCbz: begin
                        PCWrite = 1'b1;
                        PCSrc   = Zero;
                        state_d = StFetch;
                    end
                    ClsB: begin
                        PCWrite = 1'b1;
                        PCSrc   = 1'b1;
                        state_d = StFetch;
                    end
                    default: state_d = StError;
                endcase
            end
            StMem: begin
                MemRead  = (cls == ClsLdur);
                MemWrite = (cls == ClsStur);
                // A store retires in its ack cycle; a load still needs write-back.
                if (mem_ack) begin
                    if (cls == ClsLdur) begin
                        state_d = StWb;
                    end else begin
                        PCWrite = 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                state_d  = StFetch;
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StFetch;
            ir_q     <= 32'd0;
            retire_q <= 32'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            if (PCWrite) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    // Decoded operand controls are masked in FETCH so a stale IR never leaks out.
    assign Reg2Loc      = (state_q != StFetch) && dec_reg2loc;
    assign ALUSrc       = (state_q != StFetch) && dec_alusrc;
    assign ALUOp        = (state_q != StFetch) ? dec_aluop : AluAnd;
    assign ReadSelect1  = ir_q[9:5];
    assign ReadSelect2  = Reg2Loc ? ir_q[4:0] : ir_q[20:16];
    assign WriteSelect  = ir_q[4:0];
    assign illegal      = (state_q == StError);
    assign retire_count = retire_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: directed and random instructions checked cycle by cycle
// against a class/latency model of the sequencer.
module tb_legv8_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic        inst_ready;
    logic        Zero;
    logic        mem_ack;
    logic        Reg2Loc;
    logic [4:0]  ReadSelect1;
    logic [4:0]  ReadSelect2;
    logic [4:0]  WriteSelect;
    logic        ALUSrc;
    logic [3:0]  ALUOp;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        illegal;
    logic [31:0] retire_count;

    legv8_multicycle_ctrl dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .Instruction  (Instruction),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .Zero         (Zero),
        .mem_ack      (mem_ack),
        .Reg2Loc      (Reg2Loc),
        .ReadSelect1  (ReadSelect1),
        .ReadSelect2  (ReadSelect2),
        .WriteSelect  (WriteSelect),
        .ALUSrc       (ALUSrc),
        .ALUOp        (ALUOp),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .PCWrite      (PCWrite),
        .PCSrc        (PCSrc),
        .illegal      (illegal),
        .retire_count (retire_count)
    );

    always #5 CLK = ~CLK;

    localparam int CR = 0, CLD = 1, CST = 2, CCBZ = 3, CB = 4, CMOVK = 5;

    logic [10:0] rop  [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    logic [3:0]  raop [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};

    int          tests = 0;
    int          fails = 0;
    int unsigned retire_exp = 0;

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic gen(output logic [31:0] ins, output int cls, output logic [3:0] aop);
        logic [31:0] r;
        int i;
        r   = $urandom;
        cls = $urandom_range(0, 5);
        aop = 4'b0010;
        case (cls)
            CR: begin
                i   = $urandom_range(0, 3);
                ins = {rop[i], r[20:0]};
                aop = raop[i];
            end
            CLD:  ins = {11'b11111000010, r[20:0]};
            CST:  ins = {11'b11111000000, r[20:0]};
            CCBZ: begin ins = {8'b10110100, r[23:0]}; aop = 4'b0111; end
            CB:   begin ins = {6'b000101, r[25:0]}; aop = 4'b0000; end
            default: begin ins = {9'b111100101, r[22:0]}; aop = 4'b0111; end
        endcase
    endtask

    // Entered 1 time unit after a rising edge with the DUT in FETCH; returns likewise.
    task automatic run_instr(input logic [31:0] ins, input int cls, input logic [3:0] aop,
                             input int w, input logic z);
        int   len;
        logic r2l, asrc, is_mem;
        logic [4:0] rs2;
        is_mem = (cls == CLD) || (cls == CST);
        case (cls)
            CR, CMOVK: len = 4;
            CLD:       len = 5 + w;
            CST:       len = 4 + w;
            default:   len = 3;
        endcase
        r2l  = (cls == CST) || (cls == CCBZ) || (cls == CMOVK);
        asrc = (cls == CLD) || (cls == CST) || (cls == CMOVK);
        rs2  = r2l ? ins[4:0] : ins[20:16];
        for (int k = 0; k < len; k++) begin
            logic in_mem, e_rw, e_pw, e_ps;
            Instruction = (k == 0) ? ins : $urandom;
            inst_valid  = (k == 0) ? 1'b1 : 1'($urandom);
            in_mem      = is_mem && (k >= 3) && (k <= 3 + w);
            mem_ack     = in_mem ? (k == 3 + w) : 1'($urandom);
            Zero        = (k == 2) ? z : 1'($urandom);
            #3;
            e_pw = (k == len - 1);
            e_ps = e_pw && ((cls == CB) || ((cls == CCBZ) && z));
            e_rw = (((cls == CR) || (cls == CMOVK)) && k == 3) || ((cls == CLD) && k == 4 + w);
            chkb($sformatf("inst_ready c%0d k%0d", cls, k), inst_ready, k == 0);
            chkb($sformatf("MemRead c%0d k%0d", cls, k), MemRead, in_mem && cls == CLD);
            chkb($sformatf("MemWrite c%0d k%0d", cls, k), MemWrite, in_mem && cls == CST);
            chkb($sformatf("RegWrite c%0d k%0d", cls, k), RegWrite, e_rw);
            chkb($sformatf("PCWrite c%0d k%0d", cls, k), PCWrite, e_pw);
            chkb($sformatf("PCSrc c%0d k%0d", cls, k), PCSrc, e_ps);
            chkb($sformatf("illegal c%0d k%0d", cls, k), illegal, 1'b0);
            chkv($sformatf("retire_count c%0d k%0d", cls, k), retire_count, retire_exp);
            if (k >= 1) begin
                chkb($sformatf("Reg2Loc c%0d k%0d", cls, k), Reg2Loc, r2l);
                chkb($sformatf("ALUSrc c%0d k%0d", cls, k), ALUSrc, asrc);
                chkv($sformatf("ALUOp c%0d k%0d", cls, k), 32'(ALUOp), 32'(aop));
                chkv($sformatf("ReadSelect1 c%0d k%0d", cls, k), 32'(ReadSelect1), 32'(ins[9:5]));
                chkv($sformatf("ReadSelect2 c%0d k%0d", cls, k), 32'(ReadSelect2), 32'(rs2));
                chkv($sformatf("WriteSelect c%0d k%0d", cls, k), 32'(WriteSelect), 32'(ins[4:0]));
            end
            @(posedge CLK);
            #1;
        end
        retire_exp++;
        inst_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] add_ins;
        int          cls;
        logic [3:0]  aop;

        RST_N       = 1'b0;
        Instruction = 32'd0;
        inst_valid  = 1'b0;
        Zero        = 1'b0;
        mem_ack     = 1'b0;
        #12;
        chkb("reset PCWrite", PCWrite, 1'b0);
        chkb("reset RegWrite", RegWrite, 1'b0);
        chkb("reset MemRead", MemRead, 1'b0);
        chkb("reset MemWrite", MemWrite, 1'b0);
        chkb("reset Reg2Loc", Reg2Loc, 1'b0);
        chkb("reset ALUSrc", ALUSrc, 1'b0);
        chkb("reset PCSrc", PCSrc, 1'b0);
        chkb("reset illegal", illegal, 1'b0);
        chkv("reset ALUOp", 32'(ALUOp), 32'd0);
        chkv("reset retire_count", retire_count, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        add_ins = {11'b10001011000, 5'd5, 6'd0, 5'd4, 5'd6};
        run_instr(add_ins, CR, 4'b0010, 0, 1'b0);
        #3;
        chkv("retire after ADD", retire_count, 32'd1);
        #0;
        run_instr({11'b11110010100, 16'h0006, 5'd30}, CMOVK, 4'b0111, 0, 1'b0);
        run_instr({11'b11111000010, 9'd8, 2'b00, 5'd1, 5'd2}, CLD, 4'b0010, 2, 1'b0);
        run_instr({8'b10110100, 19'd5, 5'd3}, CCBZ, 4'b0111, 0, 1'b1);
        run_instr({8'b10110100, 19'd5, 5'd3}, CCBZ, 4'b0111, 0, 1'b0);
        run_instr({6'b000101, 26'd100}, CB, 4'b0000, 0, 1'b0);
        run_instr({11'b11111000000, 9'd0, 2'b00, 5'd7, 5'd8}, CST, 4'b0010, 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            gen(ins, cls, aop);
            run_instr(ins, cls, aop, $urandom_range(0, 3), 1'($urandom));
        end

        // Illegal opcode: stuck in error until reset.
        Instruction = {11'b00000000000, 21'($urandom)};
        inst_valid  = 1'b1;
        #3;
        chkb("illegal accept ready", inst_ready, 1'b1);
        @(posedge CLK);
        #4;
        chkb("illegal decode flag", illegal, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK);
            #1;
            inst_valid = 1'b1;
            mem_ack    = 1'($urandom);
            #3;
            chkb($sformatf("illegal flag k%0d", k), illegal, 1'b1);
            chkb($sformatf("illegal ready k%0d", k), inst_ready, 1'b0);
            chkb($sformatf("illegal PCWrite k%0d", k), PCWrite, 1'b0);
            chkb($sformatf("illegal RegWrite k%0d", k), RegWrite, 1'b0);
            chkb($sformatf("illegal MemRead k%0d", k), MemRead, 1'b0);
        end
        inst_valid = 1'b0;
        RST_N      = 1'b0;
        #1;
        chkb("illegal cleared by reset", illegal, 1'b0);
        chkv("retire cleared by reset", retire_count, 32'd0);
        retire_exp = 0;
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        run_instr(add_ins, CR, 4'b0010, 0, 1'b0);

        // Reset while an LDUR waits for mem_ack.
        Instruction = {11'b11111000010, 9'd4, 2'b00, 5'd9, 5'd10};
        inst_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_ack = (k >= 3) ? 1'b0 : 1'($urandom);
            #3;
            if (k >= 3) chkb($sformatf("abort MemRead k%0d", k), MemRead, 1'b1);
            if (k < 4) begin
                @(posedge CLK);
                #1;
                inst_valid = 1'b0;
            end
        end
        RST_N = 1'b0;
        #1;
        chkb("abort MemRead drop", MemRead, 1'b0);
        chkb("abort RegWrite", RegWrite, 1'b0);
        chkb("abort PCWrite", PCWrite, 1'b0);
        chkv("abort retire_count", retire_count, 32'd0);
        retire_exp = 0;
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        run_instr(add_ins, CR, 4'b0010, 0, 1'b0);
        #3;
        chkv("retire after abort+ADD", retire_count, 32'd1);
        chkb("ready after abort+ADD", inst_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
